// File: rtl/mrd_stage_fsm_ctrl.sv
// Stage sequencer for the mixed-radix DFT memory engine: sink one frame, run every
// factor stage through read/butterfly/write, then hand off to output streaming.
module mrd_stage_fsm_ctrl #(
    parameter int WAIT_RD = 4,
    parameter int WD_CYC  = 4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sink_valid,
    input  logic        sink_sop,
    input  logic        sink_eop,
    output logic        sink_ready,
    input  logic [11:0] dftpts,
    input  logic [2:0]  num_of_factors,
    input  logic        rd_end,
    input  logic        wr_end,
    input  logic        source_end,
    output logic [2:0]  fsm,
    output logic [2:0]  fsm_r,
    output logic [2:0]  cnt_stage,
    output logic [2:0]  nf_lat,
    output logic        busy,
    output logic        err_len,
    output logic        err_wd
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SINK        = 3'd1,
        WAIT_TO_RD  = 3'd2,
        RD          = 3'd3,
        WAIT_WR_END = 3'd4,
        SOURCE      = 3'd5
    } state_t;

    localparam int WAIT_W = (WAIT_RD > 1) ? $clog2(WAIT_RD) : 1;
    localparam int WD_W   = $clog2(WD_CYC + 1);

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WD_W-1:0]     wd_cnt;
    logic                wr_pend;
    logic [11:0]         smp_cnt;
    logic [11:0]         smp_next;
    logic [11:0]         dft_lat;

    function automatic logic [2:0] clamp_nf(input logic [2:0] n);
        if (n == 3'd0) return 3'd1;
        if (n > 3'd6)  return 3'd6;
        return n;
    endfunction

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    assign fsm        = state;
    assign sink_ready = (state == IDLE) || (state == SINK);
    assign busy       = (state != IDLE);

    // An sop inside the frame restarts the count instead of incrementing it.
    always_comb begin
        smp_next = sink_sop ? 12'd1 : sat_inc(smp_cnt);
    end

    // Frame bookkeeping carries no reset; it is rewritten at every sop.
    always_ff @(posedge clk) begin
        if (state == IDLE && sink_valid && sink_sop) begin
            smp_cnt <= 12'd1;
            dft_lat <= dftpts;
        end else if (state == SINK && sink_valid) begin
            smp_cnt <= smp_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            fsm_r     <= IDLE;
            cnt_stage <= 3'd0;
            nf_lat    <= 3'd1;
            err_len   <= 1'b0;
            err_wd    <= 1'b0;
            wr_pend   <= 1'b0;
            wait_cnt  <= '0;
            wd_cnt    <= '0;
        end else begin
            fsm_r <= state;
            case (state)
                IDLE: begin
                    if (sink_valid && sink_sop) begin
                        state     <= SINK;
                        nf_lat    <= clamp_nf(num_of_factors);
                        cnt_stage <= 3'd0;
                        err_len   <= 1'b0;
                        err_wd    <= 1'b0;
                        wr_pend   <= 1'b0;
                    end
                end
                SINK: begin
                    if (sink_valid && sink_eop) begin
                        state    <= WAIT_TO_RD;
                        wait_cnt <= WAIT_W'(WAIT_RD - 1);
                        err_len  <= (smp_next != dft_lat);
                    end
                end
                WAIT_TO_RD: begin
                    if (wait_cnt == '0) state <= RD;
                    else                wait_cnt <= wait_cnt - 1'b1;
                end
                RD: begin
                    // A write completion may overtake the read completion; remember it.
                    if (wr_end) wr_pend <= 1'b1;
                    if (rd_end) begin
                        state  <= WAIT_WR_END;
                        wd_cnt <= '0;
                    end
                end
                WAIT_WR_END: begin
                    if (wr_end || wr_pend) begin
                        wr_pend <= 1'b0;
                        if (cnt_stage == nf_lat - 3'd1) begin
                            state <= SOURCE;
                        end else begin
                            cnt_stage <= cnt_stage + 3'd1;
                            state     <= WAIT_TO_RD;
                            wait_cnt  <= WAIT_W'(WAIT_RD - 1);
                        end
                    end else if (wd_cnt == WD_W'(WD_CYC - 1)) begin
                        err_wd <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                SOURCE: begin
                    if (source_end) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mrd_stage_fsm_ctrl.sv
// Directed bench for mrd_stage_fsm_ctrl: frame sequencing, length error, Rd timing,
// early wr_end, watchdog abort, factor clamping and mid-frame reset.
module tb_mrd_stage_fsm_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sink_valid, sink_sop, sink_eop;
    logic        sink_ready;
    logic [11:0] dftpts;
    logic [2:0]  num_of_factors;
    logic        rd_end, wr_end, source_end;
    logic [2:0]  fsm, fsm_r, cnt_stage, nf_lat;
    logic        busy, err_len, err_wd;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mrd_stage_fsm_ctrl #(.WAIT_RD(4), .WD_CYC(4095)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sink_valid     (sink_valid),
        .sink_sop       (sink_sop),
        .sink_eop       (sink_eop),
        .sink_ready     (sink_ready),
        .dftpts         (dftpts),
        .num_of_factors (num_of_factors),
        .rd_end         (rd_end),
        .wr_end         (wr_end),
        .source_end     (source_end),
        .fsm            (fsm),
        .fsm_r          (fsm_r),
        .cnt_stage      (cnt_stage),
        .nf_lat         (nf_lat),
        .busy           (busy),
        .err_len        (err_len),
        .err_wd         (err_wd)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_rd();
        int k = 0;
        while (fsm != 3'd3 && k < 50) begin
            tick();
            k++;
        end
        if (fsm != 3'd3) chk("rd_timeout", fsm, 3);
    endtask

    task automatic send_frame(input int nf, input int dft, input int nb,
                              input int exp_nf, input int exp_err);
        num_of_factors = 3'(nf);
        dftpts         = 12'(dft);
        for (int i = 0; i < nb; i++) begin
            sink_valid = 1'b1;
            sink_sop   = (i == 0);
            sink_eop   = (i == nb - 1);
            tick();
            if (i == 0) begin
                chk("enter_sink", fsm, 1);
                dftpts = 12'hABC;
            end
        end
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
        chk("eop_to_wait", fsm, 2);
        chk("err_len", err_len, exp_err);
        chk("nf_lat", nf_lat, exp_nf);
        chk("ready_low", sink_ready, 0);
        repeat (3) tick();
        chk("wait_4th", fsm, 2);
        tick();
        chk("rd_at_t5", fsm, 3);
    endtask

    task automatic do_stages(input int nst, input bit same, input int stop);
        for (int s = 0; s < stop; s++) begin
            wait_rd();
            chk("rd_entry", (fsm_r != 3'd3), 1);
            chk("stage", cnt_stage, s);
            rd_end = 1'b1;
            wr_end = same;
            tick();
            rd_end = 1'b0;
            wr_end = 1'b0;
            chk("wait_wr", fsm, 4);
            if (!same) begin
                tick();
                chk("wr_hold", fsm, 4);
                wr_end = 1'b1;
                tick();
                wr_end = 1'b0;
            end else begin
                tick();
            end
            chk("stage_done", fsm, (s == nst - 1) ? 5 : 2);
            if (s != nst - 1) chk("stage_inc", cnt_stage, s + 1);
        end
        if (stop < nst) begin
            wait_rd();
        end else begin
            chk("src_stage", cnt_stage, nst - 1);
            source_end = 1'b1;
            tick();
            source_end = 1'b0;
            chk("src_idle", fsm, 0);
            chk("stage_held", cnt_stage, nst - 1);
            chk("busy_low", busy, 0);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        dftpts = '0; num_of_factors = '0;
        rd_end = 1'b0; wr_end = 1'b0; source_end = 1'b0;
        tick();
        tick();
        chk("rst_fsm", fsm, 0);
        chk("rst_fsm_r", fsm_r, 0);
        chk("rst_stage", cnt_stage, 0);
        chk("rst_nf", nf_lat, 1);
        chk("rst_busy", busy, 0);
        chk("rst_errs", {err_len, err_wd}, 0);
        chk("rst_ready", sink_ready, 1);
        rst_n = 1'b1;
        tick();

        // Beat without sop in Idle is ignored.
        sink_valid = 1'b1;
        tick();
        sink_valid = 1'b0;
        chk("idle_nosop", fsm, 0);

        // Nominal frame, three stages.
        send_frame(3, 12, 12, 3, 0);
        do_stages(3, 1'b0, 3);
        chk("err_len_end", err_len, 0);

        // Short frame, rd_end and wr_end together.
        send_frame(2, 12, 10, 2, 1);
        do_stages(2, 1'b1, 2);
        chk("err_len_sticky", err_len, 1);

        // Watchdog: wr_end withheld.
        send_frame(1, 12, 12, 1, 0);
        rd_end = 1'b1;
        tick();
        rd_end = 1'b0;
        chk("wd_enter", fsm, 4);
        n = 0;
        while (fsm == 3'd4 && n < 5000) begin
            tick();
            n++;
        end
        chk("wd_cycles", n, 4095);
        chk("wd_err", err_wd, 1);
        chk("wd_idle", fsm, 0);
        chk("wd_ready", sink_ready, 1);

        // nf=0 clamps to one stage; new sop clears err_wd.
        send_frame(0, 12, 12, 1, 0);
        chk("wd_cleared", err_wd, 0);
        do_stages(1, 1'b0, 1);

        // nf=7 clamps to six stages.
        send_frame(7, 12, 12, 6, 0);
        do_stages(6, 1'b0, 6);

        // Reset during stage 2 Rd.
        send_frame(7, 12, 12, 6, 0);
        do_stages(6, 1'b0, 2);
        chk("pre_rst_stage", cnt_stage, 2);
        rst_n = 1'b0;
        tick();
        chk("mrst_fsm", fsm, 0);
        chk("mrst_fsm_r", fsm_r, 0);
        chk("mrst_stage", cnt_stage, 0);
        chk("mrst_nf", nf_lat, 1);
        chk("mrst_flags", {busy, err_len, err_wd}, 0);
        chk("mrst_ready", sink_ready, 1);
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
